// File: rtl/aes_arbiter_if.sv
// aes_arbiter_if: request, core and result signals shared between the arbiter and its surroundings.
interface aes_arbiter_if;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_state, req1_state;
    logic [127:0] req0_key, req1_key;
    logic [127:0] aes_state, aes_key, aes_out;
    logic         res0_valid, res1_valid;
    logic         res0_ready, res1_ready;
    logic [127:0] res0_data, res1_data;
    logic         busy;

    modport slave (
        input  req0_valid, req1_valid, req0_state, req1_state, req0_key, req1_key,
        input  aes_out, res0_ready, res1_ready,
        output req0_ready, req1_ready, aes_state, aes_key,
        output res0_valid, res1_valid, res0_data, res1_data, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_state, req1_state, req0_key, req1_key,
        output aes_out, res0_ready, res1_ready,
        input  req0_ready, req1_ready, aes_state, aes_key,
        input  res0_valid, res1_valid, res0_data, res1_data, busy
    );
endinterface

// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin sharing of one pipelined aes_128 core between two requesters,
// with tagged results steered into per-requester credit-protected FIFOs.
module aes_arbiter #(
    parameter int AES_LAT    = 20,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    aes_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   FD  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FDC = CW'(FIFO_DEPTH);

    logic [1:0]         req_v, rdy, elig, grant, push, pop, res_v;
    logic [CW-1:0]      infl [2];
    logic [CW-1:0]      cnt [2];
    logic [CW-1:0]      infl_n [2];
    logic [CW-1:0]      cnt_n [2];
    logic [PW-1:0]      wp [2];
    logic [PW-1:0]      rp [2];
    logic [127:0]       mem [2][FIFO_DEPTH];
    logic [127:0]       st_q, key_q;
    logic [AES_LAT-1:0] tv, tid;
    logic               last, iss_v, iss_id, busy_q;

    // Credit counts both blocks still inside the core and results parked in the FIFO.
    always_comb begin
        req_v = {bus.req1_valid, bus.req0_valid};
        rdy   = {bus.res1_ready, bus.res0_ready};
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst && req_v[i] && (({1'b0, infl[i]} + {1'b0, cnt[i]}) < FD);
            push[i] = tv[AES_LAT-1] && (tid[AES_LAT-1] == i[0]);
            pop[i]  = res_v[i] && rdy[i];
        end
        grant = (elig == 2'b11) ? (last ? 2'b01 : 2'b10) : elig;
        for (int i = 0; i < 2; i++) begin
            infl_n[i] = infl[i] + CW'(grant[i]) - CW'(push[i]);
            cnt_n[i]  = cnt[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last   <= 1'b1;
            iss_v  <= 1'b0;
            iss_id <= 1'b0;
            tv     <= '0;
            st_q   <= '0;
            key_q  <= '0;
            busy_q <= 1'b0;
            res_v  <= '0;
            for (int i = 0; i < 2; i++) begin
                infl[i] <= '0;
                cnt[i]  <= '0;
                wp[i]   <= '0;
                rp[i]   <= '0;
            end
        end else begin
            if (|grant) begin
                st_q  <= grant[1] ? bus.req1_state : bus.req0_state;
                key_q <= grant[1] ? bus.req1_key : bus.req0_key;
                last  <= grant[1];
            end
            iss_v  <= |grant;
            iss_id <= grant[1];
            tv     <= (tv << 1) | AES_LAT'(iss_v);
            tid    <= (tid << 1) | AES_LAT'(iss_id);
            for (int i = 0; i < 2; i++) begin
                assert (!(push[i] && cnt[i] == FDC));
                infl[i]  <= infl_n[i];
                cnt[i]   <= cnt_n[i];
                res_v[i] <= cnt_n[i] != '0;
                if (push[i]) begin
                    mem[i][wp[i]] <= bus.aes_out;
                    wp[i]         <= wp[i] + 1'b1;
                end
                if (pop[i])
                    rp[i] <= rp[i] + 1'b1;
            end
            busy_q <= |{infl_n[0], infl_n[1], cnt_n[0], cnt_n[1]};
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.aes_state  = st_q;
    assign bus.aes_key    = key_q;
    assign bus.res0_valid = res_v[0];
    assign bus.res1_valid = res_v[1];
    assign bus.res0_data  = mem[0][rp[0]];
    assign bus.res1_data  = mem[1][rp[1]];
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed scenarios against a behavioural AES_LAT-deep core model.
module tb_aes_arbiter;
    localparam int L = 20;
    localparam int D = 4;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0  = 128'ha5a5a5a5_00000000_11111111_5a5a5a5a;
    localparam logic [127:0] K1  = 128'h0f0f0f0f_12345678_9abcdef0_f0f0f0f0;
    localparam logic [127:0] B0  = 128'h1000;
    localparam logic [127:0] B1  = 128'h2000;
    localparam logic [127:0] C0  = 128'h3000;
    localparam logic [127:0] C1  = 128'h4000;
    localparam logic [127:0] E0  = 128'h5000;
    localparam logic [127:0] F0  = 128'h6000;
    localparam logic [127:0] G0  = 128'h7777;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_arbiter_if bus ();
    aes_arbiter #(.AES_LAT(L), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Core stand-in: the known vector maps to its real ciphertext, anything else to state^key.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        return (s == PT && k == KEY) ? CT : (s ^ k);
    endfunction

    logic [127:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= core_f(bus.aes_state, bus.aes_key);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.aes_out = pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] got0[$];
    logic [127:0] got1[$];
    int cyc0[$];
    always @(negedge clk) begin
        if (bus.res0_valid && bus.res0_ready) begin
            got0.push_back(bus.res0_data);
            cyc0.push_back(cyc);
        end
        if (bus.res1_valid && bus.res1_ready) got1.push_back(bus.res1_data);
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_state = '0;
        bus.req1_state = '0;
        bus.req0_key   = '0;
        bus.req1_key   = '0;
        bus.res0_ready = 1'b1;
        bus.res1_ready = 1'b1;
    endtask

    task automatic apply_reset;
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic clear_logs;
        got0.delete();
        got1.delete();
        cyc0.delete();
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        n_checks++;
        if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
        n_checks++;
        if (bus.res0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res0_valid: got %b want 0", bus.res0_valid); end
        n_checks++;
        if (bus.res1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res1_valid: got %b want 0", bus.res1_valid); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.aes_state !== 128'h0) begin n_fail++; $display("FAIL reset_aes_state: got %h want 0", bus.aes_state); end
        n_checks++;
        if (bus.aes_key !== 128'h0) begin n_fail++; $display("FAIL reset_aes_key: got %h want 0", bus.aes_key); end
        step();
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single;
        int lat;
        logic seen1;
        logic [127:0] data;
        lat = -1;
        seen1 = 1'b0;
        data = '0;
        clear_logs();
        step();
        bus.req0_valid = 1'b1;
        bus.req0_state = PT;
        bus.req0_key   = KEY;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", bus.req0_ready); end
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.aes_state !== PT || bus.aes_key !== KEY) begin
            n_fail++; $display("FAIL single_issue: got %h/%h want %h/%h", bus.aes_state, bus.aes_key, PT, KEY);
        end
        for (int k = 2; k <= 40; k++) begin
            step();
            @(negedge clk);
            if (bus.res1_valid) seen1 = 1'b1;
            if (lat < 0 && bus.res0_valid) begin
                lat = k;
                data = bus.res0_data;
            end
        end
        n_checks++;
        if (lat != L + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, L + 2); end
        n_checks++;
        if (data !== CT) begin n_fail++; $display("FAIL single_data: got %h want %h", data, CT); end
        n_checks++;
        if (seen1 !== 1'b0) begin n_fail++; $display("FAIL single_res1_idle: got %b want 0", seen1); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_contention;
        int i0, i1;
        i0 = 0;
        i1 = 0;
        apply_reset();
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            bus.req0_valid = 1'b1;
            bus.req0_state = B0 + 128'(i0);
            bus.req0_key   = K0;
            bus.req1_valid = 1'b1;
            bus.req1_state = B1 + 128'(i1);
            bus.req1_key   = K1;
            @(negedge clk);
            n_checks++;
            if (bus.req0_ready !== (c % 2 == 0) || bus.req1_ready !== (c % 2 == 1)) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %b%b want %b%b", c, bus.req1_ready, bus.req0_ready, c % 2 == 1, c % 2 == 0);
            end
            if (bus.req0_ready) i0++;
            if (bus.req1_ready) i1++;
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (40) step();
        n_checks++;
        if (got0.size() != 4 || got1.size() != 4) begin
            n_fail++; $display("FAIL contention_counts: got %0d/%0d want 4/4", got0.size(), got1.size());
        end
        for (int n = 0; n < 4; n++) begin
            if (n < got0.size()) begin
                n_checks++;
                if (got0[n] !== ((B0 + 128'(n)) ^ K0)) begin n_fail++; $display("FAIL contention_res0[%0d]: got %h want %h", n, got0[n], (B0 + 128'(n)) ^ K0); end
            end
            if (n < got1.size()) begin
                n_checks++;
                if (got1[n] !== ((B1 + 128'(n)) ^ K1)) begin n_fail++; $display("FAIL contention_res1[%0d]: got %h want %h", n, got1[n], (B1 + 128'(n)) ^ K1); end
            end
        end
    endtask

    task automatic test_backpressure;
        int i0, acc, extra;
        logic found, leak;
        i0 = 0;
        acc = 0;
        extra = 0;
        found = 1'b0;
        leak = 1'b0;
        apply_reset();
        clear_logs();
        bus.res0_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            bus.req0_valid = 1'b1;
            bus.req0_state = C0 + 128'(i0);
            bus.req0_key   = K0;
            @(negedge clk);
            n_checks++;
            if (bus.req0_ready !== (c < 4)) begin n_fail++; $display("FAIL credit_ready[%0d]: got %b want %b", c, bus.req0_ready, c < 4); end
            if (bus.req0_ready) begin i0++; acc++; end
        end
        n_checks++;
        if (acc != 4) begin n_fail++; $display("FAIL credit_accepts: got %0d want 4", acc); end
        step();
        bus.req1_valid = 1'b1;
        bus.req1_state = C1;
        bus.req1_key   = K1;
        @(negedge clk);
        n_checks++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL credit_other_req: got r1=%b r0=%b want r1=1 r0=0", bus.req1_ready, bus.req0_ready);
        end
        step();
        bus.req1_valid = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            @(negedge clk);
            if (bus.req0_ready) leak = 1'b1;
            if (bus.res0_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL credit_res_wait: got timeout want res0_valid"); end
        repeat (5) begin
            step();
            @(negedge clk);
            if (bus.req0_ready) leak = 1'b1;
        end
        n_checks++;
        if (leak) begin n_fail++; $display("FAIL credit_hold: got req0_ready=1 want 0 while full"); end
        for (int c = 0; c < 7; c++) begin
            step();
            bus.res0_ready = (c == 0);
            bus.req0_state = C0 + 128'(i0);
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (bus.res0_valid !== 1'b1 || bus.req0_ready !== 1'b0) begin
                    n_fail++; $display("FAIL credit_pop_cycle: got v=%b r=%b want v=1 r=0", bus.res0_valid, bus.req0_ready);
                end
            end
            if (bus.req0_ready) begin i0++; extra++; end
        end
        n_checks++;
        if (extra != 1) begin n_fail++; $display("FAIL credit_one_more: got %0d want 1", extra); end
        step();
        bus.req0_valid = 1'b0;
        bus.res0_ready = 1'b1;
        repeat (40) step();
        n_checks++;
        if (got0.size() != 5) begin n_fail++; $display("FAIL credit_drain_count: got %0d want 5", got0.size()); end
        for (int n = 0; n < 5; n++) begin
            if (n < got0.size()) begin
                n_checks++;
                if (got0[n] !== ((C0 + 128'(n)) ^ K0)) begin n_fail++; $display("FAIL credit_res0[%0d]: got %h want %h", n, got0[n], (C0 + 128'(n)) ^ K0); end
            end
        end
    endtask

    task automatic test_stream;
        int i0;
        i0 = 0;
        clear_logs();
        idle_inputs();
        for (int c = 0; c < 120 && i0 < 8; c++) begin
            step();
            bus.req0_valid = 1'b1;
            bus.req0_state = E0 + 128'(i0);
            bus.req0_key   = K0;
            @(negedge clk);
            if (bus.req0_ready) i0++;
        end
        n_checks++;
        if (i0 != 8) begin n_fail++; $display("FAIL stream_accepts: got %0d want 8", i0); end
        step();
        bus.req0_valid = 1'b0;
        repeat (40) step();
        n_checks++;
        if (got0.size() != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", got0.size()); end
        for (int n = 0; n < 8; n++) begin
            if (n < got0.size()) begin
                n_checks++;
                if (got0[n] !== ((E0 + 128'(n)) ^ K0)) begin n_fail++; $display("FAIL stream_res0[%0d]: got %h want %h", n, got0[n], (E0 + 128'(n)) ^ K0); end
            end
        end
        for (int k = 1; k < 4; k++) begin
            if (k < cyc0.size()) begin
                n_checks++;
                if (cyc0[k] - cyc0[0] != k) begin n_fail++; $display("FAIL stream_gap[%0d]: got %0d want %0d", k, cyc0[k] - cyc0[0], k); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic bad_v, bad_b;
        int lat;
        logic [127:0] data;
        bad_v = 1'b0;
        bad_b = 1'b0;
        lat = -1;
        data = '0;
        clear_logs();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            bus.req0_valid = 1'b1;
            bus.req0_state = F0 + 128'(c);
            bus.req0_key   = K0;
            @(negedge clk);
            n_checks++;
            if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_accept[%0d]: got %b want 1", c, bus.req0_ready); end
        end
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < L + 4; k++) begin
            @(negedge clk);
            if (bus.res0_valid || bus.res1_valid) bad_v = 1'b1;
            if (bus.busy) bad_b = 1'b1;
            step();
        end
        n_checks++;
        if (bad_v) begin n_fail++; $display("FAIL midrst_res_valid: got 1 want 0 after reset"); end
        n_checks++;
        if (bad_b) begin n_fail++; $display("FAIL midrst_busy: got 1 want 0 after reset"); end
        n_checks++;
        if (got0.size() != 0) begin n_fail++; $display("FAIL midrst_discard: got %0d results want 0", got0.size()); end
        bus.req0_valid = 1'b1;
        bus.req0_state = G0;
        bus.req0_key   = K0;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_new_accept: got %b want 1", bus.req0_ready); end
        step();
        bus.req0_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.res0_valid) begin
                lat = k;
                data = bus.res0_data;
            end
            step();
        end
        n_checks++;
        if (lat != L + 2) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, L + 2); end
        n_checks++;
        if (data !== (G0 ^ K0)) begin n_fail++; $display("FAIL midrst_data: got %h want %h", data, G0 ^ K0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
